rau_req_sched: RTL and testbench

//  Front-end scheduler for the register allocation unit (RAU). Accepts allocation requests from TM
//  (valid/ready) and warp-exit notices from IB (buffered in a small FIFO). Serialises them into
//  one-at-a-time RAU commands and waits for RAU completion. Holds an allocation until the RAU

---
 rtl/rau_req_sched.sv | 212 +++++++++++++++++++++
 tb/tb_rau_req_sched.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rau_req_sched.sv
// rau_req_sched
// Front-end scheduler for the register allocation unit. Alloc requests from TM
// are held one at a time; exit notices from IB are buffered in a small FIFO.
// Commands are sent to the RAU one at a time, and the scheduler waits for
// rau_done before it issues the next one. An alloc is held back until the RAU
// reports enough free registers. Exits win over a fitting alloc, but only for
// MAX_EXIT_BURST exits in a row.
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   tm_req_*                 alloc request handshake and payload from TM
//   ib_exit_*                exit notice handshake and warp ID from IB
//   rau_available            free registers reported by the RAU
//   rau_done                 one-cycle completion pulse from the RAU
//   rau_allo_en/rau_exit_en  one-cycle command pulses to the RAU
//   rau_hwwarp/swwarp/nreq   command payload, held until the next command
//   sched_busy               scheduler is not idle
//   timeout_err              sticky flag: the RAU did not answer in time
module rau_req_sched #(
  parameter int WARP_W         = 3,
  parameter int SWW_W          = 32,
  parameter int NREQ_W         = 3,
  parameter int AVAIL_W        = 5,
  parameter int EXIT_DEPTH     = 4,
  parameter int MAX_EXIT_BURST = 2,
  parameter int TIMEOUT        = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tm_req_valid,
  output logic               tm_req_ready,
  input  logic [WARP_W-1:0]  tm_req_hwwarp,
  input  logic [SWW_W-1:0]   tm_req_swwarp,
  input  logic [NREQ_W-1:0]  tm_req_nreq,
  input  logic               ib_exit_valid,
  output logic               ib_exit_ready,
  input  logic [WARP_W-1:0]  ib_exit_warpid,
  input  logic [AVAIL_W-1:0] rau_available,
  input  logic               rau_done,
  output logic               rau_allo_en,
  output logic               rau_exit_en,
  output logic [WARP_W-1:0]  rau_hwwarp,
  output logic [SWW_W-1:0]   rau_swwarp,
  output logic [NREQ_W-1:0]  rau_nreq,
  output logic               sched_busy,
  output logic               timeout_err
);

  localparam int PTR_W   = (EXIT_DEPTH > 1) ? $clog2(EXIT_DEPTH) : 1;
  localparam int CNT_W   = PTR_W + 1;
  localparam int BURST_W = $clog2(MAX_EXIT_BURST + 1);
  localparam int TMR_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int CMP_W   = ((NREQ_W > AVAIL_W) ? NREQ_W : AVAIL_W) + 1;

  localparam logic [CNT_W-1:0]   DEPTH_CNT  = CNT_W'(EXIT_DEPTH);
  localparam logic [BURST_W-1:0] BURST_MAX  = BURST_W'(MAX_EXIT_BURST);
  localparam logic [TMR_W-1:0]   TIMER_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE_ALLO,
    ISSUE_EXIT,
    WAIT
  } state_t;

  state_t state, next_state;

  logic                alloc_pend;
  logic [WARP_W-1:0]   alloc_hwwarp;
  logic [SWW_W-1:0]    alloc_swwarp;
  logic [NREQ_W-1:0]   alloc_nreq;

  logic [WARP_W-1:0]   fifo_mem [EXIT_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    fifo_cnt;

  logic [BURST_W-1:0]  burst_cnt;
  logic [TMR_W-1:0]    timer;

  logic tm_accept, fifo_push, fifo_empty, fits, exit_ok;
  logic issue_allo, issue_exit, timeout_hit;

  // Ready is based only on the current count, so a full FIFO refuses a push
  // even in the same cycle that it pops an entry.
  assign tm_req_ready  = !alloc_pend;
  assign ib_exit_ready = (fifo_cnt < DEPTH_CNT);
  assign tm_accept     = tm_req_valid && tm_req_ready;
  assign fifo_push     = ib_exit_valid && ib_exit_ready;
  assign fifo_empty    = (fifo_cnt == '0);

  // Both sides are zero-extended to a common width before the unsigned compare.
  assign fits    = (CMP_W'(alloc_nreq) <= CMP_W'(rau_available));
  assign exit_ok = !fifo_empty && (!alloc_pend || !fits || (burst_cnt < BURST_MAX));

  assign rau_allo_en = (state == ISSUE_ALLO);
  assign rau_exit_en = (state == ISSUE_EXIT);
  assign sched_busy  = (state != IDLE);

  // Next-state logic. Each ISSUE state lasts one cycle. WAIT leaves on
  // rau_done or when the timer expires.
  always_comb begin
    next_state  = state;
    issue_allo  = 1'b0;
    issue_exit  = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (exit_ok) begin
          next_state = ISSUE_EXIT;
          issue_exit = 1'b1;
        end else if (alloc_pend && fits) begin
          next_state = ISSUE_ALLO;
          issue_allo = 1'b1;
        end
      end
      ISSUE_ALLO, ISSUE_EXIT: next_state = WAIT;
      WAIT: begin
        if (rau_done) begin
          next_state = IDLE;
        end else if (timer == TIMER_LAST) begin
          next_state  = IDLE;
          timeout_hit = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register, WAIT timer and the sticky timeout flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      timer       <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= next_state;
      if (state == WAIT && next_state == WAIT) timer <= timer + TMR_W'(1);
      else                                     timer <= '0;
      if (timeout_hit) timeout_err <= 1'b1;
    end
  end

  // Hold one alloc request. The request is consumed when its command is issued.
  always_ff @(posedge clk) begin
    if (!rst) begin
      alloc_pend   <= 1'b0;
      alloc_hwwarp <= '0;
      alloc_swwarp <= '0;
      alloc_nreq   <= '0;
    end else if (tm_accept) begin
      alloc_pend   <= 1'b1;
      alloc_hwwarp <= tm_req_hwwarp;
      alloc_swwarp <= tm_req_swwarp;
      alloc_nreq   <= tm_req_nreq;
    end else if (issue_allo) begin
      alloc_pend <= 1'b0;
    end
  end

  // Count consecutive exits that overtake a pending alloc. The count starts
  // again once the alloc goes out, or when no alloc is pending.
  always_ff @(posedge clk) begin
    if (!rst) begin
      burst_cnt <= '0;
    end else if (issue_allo || !alloc_pend) begin
      burst_cnt <= '0;
    end else if (issue_exit && burst_cnt != BURST_MAX) begin
      burst_cnt <= burst_cnt + BURST_W'(1);
    end
  end

  // Exit FIFO storage. The data does not need a reset because the count gates it.
  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[wr_ptr] <= ib_exit_warpid;
  end

  // Exit FIFO pointers and occupancy. A pop happens when an exit is issued.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_push)  wr_ptr <= wr_ptr + PTR_W'(1);
      if (issue_exit) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({fifo_push, issue_exit})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Command payload. It is loaded when a command is issued and held through
  // WAIT. For an exit command, swwarp and nreq are zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rau_hwwarp <= '0;
      rau_swwarp <= '0;
      rau_nreq   <= '0;
    end else if (issue_allo) begin
      rau_hwwarp <= alloc_hwwarp;
      rau_swwarp <= alloc_swwarp;
      rau_nreq   <= alloc_nreq;
    end else if (issue_exit) begin
      rau_hwwarp <= fifo_mem[rd_ptr];
      rau_swwarp <= '0;
      rau_nreq   <= '0;
    end
  end

endmodule

// File: tb/tb_rau_req_sched.sv
// Directed testbench for rau_req_sched with default parameters.
// Inputs change on the falling edge and outputs are sampled there too.
module tb_rau_req_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        tm_req_valid;
  logic        tm_req_ready;
  logic [2:0]  tm_req_hwwarp;
  logic [31:0] tm_req_swwarp;
  logic [2:0]  tm_req_nreq;
  logic        ib_exit_valid;
  logic        ib_exit_ready;
  logic [2:0]  ib_exit_warpid;
  logic [4:0]  rau_available;
  logic        rau_done;
  logic        rau_allo_en;
  logic        rau_exit_en;
  logic [2:0]  rau_hwwarp;
  logic [31:0] rau_swwarp;
  logic [2:0]  rau_nreq;
  logic        sched_busy;
  logic        timeout_err;

  int check_cnt = 0;
  int pass_cnt  = 0;

  rau_req_sched dut (
    .clk            (clk),
    .rst            (rst),
    .tm_req_valid   (tm_req_valid),
    .tm_req_ready   (tm_req_ready),
    .tm_req_hwwarp  (tm_req_hwwarp),
    .tm_req_swwarp  (tm_req_swwarp),
    .tm_req_nreq    (tm_req_nreq),
    .ib_exit_valid  (ib_exit_valid),
    .ib_exit_ready  (ib_exit_ready),
    .ib_exit_warpid (ib_exit_warpid),
    .rau_available  (rau_available),
    .rau_done       (rau_done),
    .rau_allo_en    (rau_allo_en),
    .rau_exit_en    (rau_exit_en),
    .rau_hwwarp     (rau_hwwarp),
    .rau_swwarp     (rau_swwarp),
    .rau_nreq       (rau_nreq),
    .sched_busy     (sched_busy),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  // Safety net, so a hung run still reports and stops.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    check_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Drive one handshake attempt on the TM and/or IB ports for one clock edge.
  task automatic applyStimulus(input bit tm_v, input logic [2:0] hw, input logic [31:0] sw,
                               input logic [2:0] nreq, input bit ib_v, input logic [2:0] exit_id);
    tm_req_valid   = tm_v;
    tm_req_hwwarp  = hw;
    tm_req_swwarp  = sw;
    tm_req_nreq    = nreq;
    ib_exit_valid  = ib_v;
    ib_exit_warpid = exit_id;
    cyc();
    tm_req_valid  = 1'b0;
    ib_exit_valid = 1'b0;
  endtask

  // Answer the command that has just been issued. Move into WAIT first,
  // because rau_done is ignored in the ISSUE state.
  task automatic pulseDone();
    cyc();
    rau_done = 1'b1;
    cyc();
    rau_done = 1'b0;
  endtask

  // Wait, within a limited number of cycles, for the next command pulse and
  // check its kind and payload.
  task automatic expectCmd(input string tag, input bit is_allo, input logic [2:0] hw,
                           input logic [31:0] sw, input logic [2:0] nreq, input int budget);
    bit seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      cyc();
      if (rau_allo_en || rau_exit_en) seen = 1'b1;
    end
    checkOutput({tag, "_seen"}, seen, 1);
    if (seen) begin
      checkOutput({tag, "_allo"}, rau_allo_en, is_allo);
      checkOutput({tag, "_exit"}, rau_exit_en, !is_allo);
      checkOutput({tag, "_hw"},   rau_hwwarp, hw);
      checkOutput({tag, "_sw"},   rau_swwarp, sw);
      checkOutput({tag, "_nreq"}, rau_nreq, nreq);
    end
  endtask

  // Watch for a few cycles and check that no command is issued.
  task automatic expectQuiet(input string tag, input int cycles);
    bit seen = 1'b0;
    for (int n = 0; n < cycles; n++) begin
      cyc();
      if (rau_allo_en || rau_exit_en) seen = 1'b1;
    end
    checkOutput(tag, seen, 0);
  endtask

  initial begin
    rst = 1'b0;
    tm_req_valid = 1'b0; tm_req_hwwarp = '0; tm_req_swwarp = '0; tm_req_nreq = '0;
    ib_exit_valid = 1'b0; ib_exit_warpid = '0;
    rau_available = 5'd16; rau_done = 1'b0;

    // Reset state
    repeat (3) cyc();
    checkOutput("rst_allo_en", rau_allo_en, 0);
    checkOutput("rst_exit_en", rau_exit_en, 0);
    checkOutput("rst_busy",    sched_busy, 0);
    checkOutput("rst_tmo",     timeout_err, 0);
    checkOutput("rst_hw",      rau_hwwarp, 0);
    rst = 1'b1;
    cyc();
    checkOutput("rst_tm_ready", tm_req_ready, 1);
    checkOutput("rst_ib_ready", ib_exit_ready, 1);

    // Single alloc with exact latency
    applyStimulus(1, 3'd3, 32'hABCD1234, 3'd4, 0, 3'd0);
    checkOutput("alloc_ready_low", tm_req_ready, 0);
    checkOutput("alloc_n1_no_en",  rau_allo_en, 0);
    cyc();
    checkOutput("alloc_n2_en",   rau_allo_en, 1);
    checkOutput("alloc_n2_hw",   rau_hwwarp, 3);
    checkOutput("alloc_n2_sw",   rau_swwarp, 32'hABCD1234);
    checkOutput("alloc_n2_nreq", rau_nreq, 4);
    checkOutput("alloc_n2_busy", sched_busy, 1);
    checkOutput("alloc_ready_back", tm_req_ready, 1);
    cyc();
    checkOutput("alloc_wait_pulse", rau_allo_en, 0);
    checkOutput("alloc_wait_hold",  rau_hwwarp, 3);
    rau_done = 1'b1;
    cyc();
    rau_done = 1'b0;
    checkOutput("alloc_done_idle", sched_busy, 0);

    // Insufficient space, then the exact-fit boundary
    rau_available = 5'd4;
    applyStimulus(1, 3'd5, 32'h0000_0055, 3'd6, 0, 3'd0);
    expectQuiet("nofit_quiet", 4);
    rau_available = 5'd6;
    expectCmd("fit_alloc", 1, 3'd5, 32'h0000_0055, 3'd6, 3);
    pulseDone();

    // A zero-register request fits even with nothing free
    rau_available = 5'd0;
    applyStimulus(1, 3'd1, 32'h0000_0011, 3'd0, 0, 3'd0);
    expectCmd("zero_alloc", 1, 3'd1, 32'h0000_0011, 3'd0, 3);
    pulseDone();

    // Priority, burst cap and a full FIFO, all behind a blocking exit
    rau_available = 5'd16;
    applyStimulus(0, 3'd0, 32'd0, 3'd0, 1, 3'd7);
    expectCmd("blk_exit", 0, 3'd7, 32'd0, 3'd0, 3);
    applyStimulus(1, 3'd2, 32'h0000_0022, 3'd3, 1, 3'd1);
    applyStimulus(0, 3'd0, 32'd0, 3'd0, 1, 3'd2);
    applyStimulus(0, 3'd0, 32'd0, 3'd0, 1, 3'd3);
    applyStimulus(0, 3'd0, 32'd0, 3'd0, 1, 3'd4);
    checkOutput("full_ready_low", ib_exit_ready, 0);
    applyStimulus(0, 3'd0, 32'd0, 3'd0, 1, 3'd6);
    checkOutput("full_still_low", ib_exit_ready, 0);
    checkOutput("full_blk_busy",  sched_busy, 1);
    pulseDone();
    expectCmd("ord1_exit", 0, 3'd1, 32'd0, 3'd0, 4);
    checkOutput("pop_ready_back", ib_exit_ready, 1);
    pulseDone();
    expectCmd("ord2_exit", 0, 3'd2, 32'd0, 3'd0, 4);
    pulseDone();
    expectCmd("ord3_alloc", 1, 3'd2, 32'h0000_0022, 3'd3, 4);
    pulseDone();
    expectCmd("ord4_exit", 0, 3'd3, 32'd0, 3'd0, 4);
    pulseDone();
    expectCmd("ord5_exit", 0, 3'd4, 32'd0, 3'd0, 4);
    pulseDone();
    expectQuiet("refused_push_absent", 5);
    checkOutput("ord_end_idle", sched_busy, 0);

    // Timeout: exact exit latency, then leave the RAU silent
    applyStimulus(0, 3'd0, 32'd0, 3'd0, 1, 3'd5);
    checkOutput("exit_n1_no_en", rau_exit_en, 0);
    cyc();
    checkOutput("exit_n2_en", rau_exit_en, 1);
    checkOutput("exit_n2_hw", rau_hwwarp, 5);
    repeat (64) cyc();
    checkOutput("tmo_not_yet", timeout_err, 0);
    checkOutput("tmo_wait_busy", sched_busy, 1);
    cyc();
    checkOutput("tmo_set",  timeout_err, 1);
    checkOutput("tmo_idle", sched_busy, 0);
    applyStimulus(0, 3'd0, 32'd0, 3'd0, 1, 3'd2);
    expectCmd("tmo_next_exit", 0, 3'd2, 32'd0, 3'd0, 3);
    checkOutput("tmo_sticky", timeout_err, 1);
    pulseDone();

    // Reset during WAIT with an alloc pending and two exits queued
    applyStimulus(0, 3'd0, 32'd0, 3'd0, 1, 3'd6);
    expectCmd("pre_rst_exit", 0, 3'd6, 32'd0, 3'd0, 3);
    applyStimulus(1, 3'd4, 32'h0000_0044, 3'd2, 1, 3'd1);
    applyStimulus(0, 3'd0, 32'd0, 3'd0, 1, 3'd2);
    checkOutput("pre_rst_pend", tm_req_ready, 0);
    checkOutput("pre_rst_busy", sched_busy, 1);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    checkOutput("mid_rst_allo_en", rau_allo_en, 0);
    checkOutput("mid_rst_exit_en", rau_exit_en, 0);
    checkOutput("mid_rst_hw",      rau_hwwarp, 0);
    checkOutput("mid_rst_sw",      rau_swwarp, 0);
    checkOutput("mid_rst_nreq",    rau_nreq, 0);
    checkOutput("mid_rst_busy",    sched_busy, 0);
    checkOutput("mid_rst_tmo",     timeout_err, 0);
    checkOutput("mid_rst_tm_rdy",  tm_req_ready, 1);
    checkOutput("mid_rst_ib_rdy",  ib_exit_ready, 1);
    expectQuiet("mid_rst_flushed", 5);
    checkOutput("mid_rst_end_idle", sched_busy, 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
